// File: rtl/m62_sdram_pkg.sv
// Shared definitions for the M62 SDRAM controller and its ROM download feeder.
// Holds the dispatcher state encoding, the queued write record and address helpers.
package m62_sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } loader_state_t;

  typedef struct packed {
    logic        region;
    logic [22:0] addr;
    logic [1:0]  ds;
    logic [15:0] data;
  } loader_entry_t;

  localparam logic [24:0] LOADER_PORT2_BASE = 25'h0100000;

  // Bytes at or above base belong to port2 and are rebased; bits above 23 are dropped.
  function automatic loader_entry_t make_entry(input logic [24:0] byte_addr,
                                               input logic [24:0] base,
                                               input logic [1:0]  ds,
                                               input logic [15:0] data);
    loader_entry_t e;
    logic [24:0]   rebased;
    e.region = (byte_addr >= base);
    rebased  = e.region ? (byte_addr - base) : byte_addr;
    e.addr   = rebased[23:1];
    e.ds     = ds;
    e.data   = data;
    return e;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO for queued loader words; power-of-two depth so pointers wrap freely.
// A push into a full FIFO without a simultaneous pop is dropped.
module loader_fifo
  import m62_sdram_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = loader_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/sdram_rom_loader.sv
// Packs the HPS ioctl byte stream into 16-bit SDRAM writes and dispatches them one at a time
// on port1 (CPU ROM region) or port2 (graphics region) using the controller's toggle handshake.
module sdram_rom_loader
  import m62_sdram_pkg::*;
#(
  parameter logic [24:0] PORT2_BASE = LOADER_PORT2_BASE,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port1_we,
  output logic [23:1] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic        port2_we,
  output logic [23:1] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - 1);

  loader_state_t  state;
  loader_entry_t  stage;
  loader_entry_t  head;
  logic           stage_valid;
  logic           lo_valid;
  logic [7:0]     lo;
  logic [23:0]    lo_addr;
  logic           dl_q;
  logic           cur_region;
  logic           fifo_pop;
  logic           fifo_empty;
  logic           fifo_full;
  logic [CW-1:0]  fifo_count;

  // Byte assembly: every word or orphan lands in a one-entry stage and reaches the FIFO a cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q        <= 1'b0;
      lo_valid    <= 1'b0;
      lo          <= '0;
      lo_addr     <= '0;
      stage_valid <= 1'b0;
      stage       <= '0;
    end else begin
      dl_q        <= ioctl_download;
      stage_valid <= 1'b0;
      if (ioctl_wr) begin
        if (!ioctl_addr[0]) begin
          if (lo_valid) begin
            stage_valid <= 1'b1;
            stage       <= make_entry({lo_addr, 1'b0}, PORT2_BASE, 2'b01, {8'h00, lo});
          end
          lo       <= ioctl_dout;
          lo_addr  <= ioctl_addr[24:1];
          lo_valid <= 1'b1;
        end else if (lo_valid && (lo_addr == ioctl_addr[24:1])) begin
          stage_valid <= 1'b1;
          stage       <= make_entry(ioctl_addr, PORT2_BASE, 2'b11, {ioctl_dout, lo});
          lo_valid    <= 1'b0;
        end else begin
          // Unpaired high byte; any latched low byte stays put and is flushed later.
          stage_valid <= 1'b1;
          stage       <= make_entry(ioctl_addr, PORT2_BASE, 2'b10, {ioctl_dout, 8'h00});
        end
      end else if (lo_valid && !ioctl_download) begin
        stage_valid <= 1'b1;
        stage       <= make_entry({lo_addr, 1'b0}, PORT2_BASE, 2'b01, {8'h00, lo});
        lo_valid    <= 1'b0;
      end
    end
  end

  loader_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(loader_entry_t)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (stage_valid),
    .din   (stage),
    .pop   (fifo_pop),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  // Toggle handshake: a request is pending while req != ack; address/data/ds/we hold until they match.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_region <= 1'b0;
      port1_req  <= port1_ack;
      port1_we   <= 1'b0;
      port1_a    <= '0;
      port1_ds   <= '0;
      port1_d    <= '0;
      port2_req  <= port2_ack;
      port2_we   <= 1'b0;
      port2_a    <= '0;
      port2_ds   <= '0;
      port2_d    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head.region) begin
              port2_a  <= head.addr;
              port2_ds <= head.ds;
              port2_d  <= head.data;
            end else begin
              port1_a  <= head.addr;
              port1_ds <= head.ds;
              port1_d  <= head.data;
            end
            cur_region <= head.region;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cur_region) begin
            port2_req <= ~port2_req;
            port2_we  <= 1'b1;
          end else begin
            port1_req <= ~port1_req;
            port1_we  <= 1'b1;
          end
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cur_region ? (port2_req == port2_ack) : (port1_req == port1_ack)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ioctl_wait <= 1'b0;
      done       <= 1'b0;
    end else begin
      ioctl_wait <= (fifo_count >= WAIT_LEVEL) || (lo_valid && !ioctl_download);
      if (ioctl_download && !dl_q) done <= 1'b0;
      else if (!ioctl_download && fifo_empty && (state == ST_IDLE) && !lo_valid && !stage_valid)
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_rom_loader.sv
// Bench for sdram_rom_loader: table of download vectors, back-pressure burst and reset-in-WAIT,
// with a toggle-handshake controller model feeding a scoreboard of expected writes.
module tb_sdram_rom_loader;
  import m62_sdram_pkg::*;

  localparam logic [24:0] P2B = 25'h0100000;
  localparam int W = 42;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        port1_req, port1_ack = 1'b0, port1_we;
  logic [23:1] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req, port2_ack = 1'b0, port2_we;
  logic [23:1] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        done;

  always #5 clk = ~clk;

  sdram_rom_loader dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_we(port1_we), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_we(port2_we), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d), .done(done)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  int          ack_delay = 3;
  logic        complete_now = 1'b0;
  int          p1_toggles = 0, p2_toggles = 0;
  logic        p1_active = 1'b0, p2_active = 1'b0;
  int          p1_cnt = 0, p2_cnt = 0;
  logic [W-1:0] p1_cur, p2_cur;
  logic        saw_wait = 1'b0;

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got %h want nothing (no write expected)", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", name, act, exp);
      end
    end
  endtask

  // Controller model: sees each new toggle, checks it against the scoreboard, acks after ack_delay.
  always @(negedge clk) begin
    if (ioctl_wait) saw_wait = 1'b1;
    if (port1_req != port1_ack) begin
      if (!p1_active) begin
        p1_active = 1'b1;
        p1_cnt = 0;
        p1_toggles++;
        p1_cur = {1'b0, port1_a, port1_ds, port1_d};
        check_word("port1_write", p1_cur);
        check1("port1_we", 64'(port1_we), 64'd1);
      end else if ({1'b0, port1_a, port1_ds, port1_d} !== p1_cur) begin
        checks++; failures++;
        $display("FAIL port1_stable: got %h want %h", {1'b0, port1_a, port1_ds, port1_d}, p1_cur);
      end
      p1_cnt++;
      if (p1_cnt >= ack_delay || complete_now) begin
        port1_ack = port1_req;
        p1_active = 1'b0;
      end
    end else p1_active = 1'b0;

    if (port2_req != port2_ack) begin
      if (!p2_active) begin
        p2_active = 1'b1;
        p2_cnt = 0;
        p2_toggles++;
        p2_cur = {1'b1, port2_a, port2_ds, port2_d};
        check_word("port2_write", p2_cur);
        check1("port2_we", 64'(port2_we), 64'd1);
      end else if ({1'b1, port2_a, port2_ds, port2_d} !== p2_cur) begin
        checks++; failures++;
        $display("FAIL port2_stable: got %h want %h", {1'b1, port2_a, port2_ds, port2_d}, p2_cur);
      end
      p2_cnt++;
      if (p2_cnt >= ack_delay || complete_now) begin
        port2_ack = port2_req;
        p2_active = 1'b0;
      end
    end else p2_active = 1'b0;

    if (p1_active && p2_active) begin
      checks++; failures++;
      $display("FAIL one_outstanding: got 2 pending requests want at most 1");
    end
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] b);
    int n = 0;
    while (ioctl_wait && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL wait_release: got ioctl_wait stuck for %0d clk want release", n);
    end
    ioctl_addr = a;
    ioctl_dout = b;
    ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check1(name, 64'(done), 64'd1);
    check1("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [24:0]  a0;
    logic [7:0]   b0;
    logic         has1;
    logic [24:0]  a1;
    logic [7:0]   b1;
    int           n_exp;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    int           t1;
    int           t2;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  function automatic logic [7:0] burst_byte(input int i);
    return 8'hA0 + 8'(i);
  endfunction

  initial begin
    int t1, t2;
    int n;
    vecs[0] = '{25'h0, 8'h34, 1'b1, 25'h1, 8'h12, 1, {1'b0, 23'h0, 2'b11, 16'h1234}, '0, 1, 0};
    vecs[1] = '{P2B, 8'hAA, 1'b1, P2B + 25'd1, 8'hBB, 1, {1'b1, 23'h0, 2'b11, 16'hBBAA}, '0, 0, 1};
    vecs[2] = '{25'h6, 8'h5A, 1'b0, 25'h0, 8'h00, 1, {1'b0, 23'h3, 2'b01, 16'h005A}, '0, 1, 0};
    vecs[3] = '{25'h9, 8'hC3, 1'b0, 25'h0, 8'h00, 1, {1'b0, 23'h4, 2'b10, 16'hC300}, '0, 1, 0};
    vecs[4] = '{25'h100, 8'h11, 1'b1, 25'h103, 8'h22, 2, {1'b0, 23'h81, 2'b10, 16'h2200},
                {1'b0, 23'h80, 2'b01, 16'h0011}, 2, 0};
    vecs[5] = '{25'h10, 8'h77, 1'b1, 25'h12, 8'h88, 2, {1'b0, 23'h8, 2'b01, 16'h0077},
                {1'b0, 23'h9, 2'b01, 16'h0088}, 2, 0};
    vecs[6] = '{P2B + 25'h20, 8'h01, 1'b1, P2B + 25'h21, 8'h02, 1, {1'b1, 23'h10, 2'b11, 16'h0201}, '0, 0, 1};
    vecs[7] = '{25'h1FFFFFE, 8'h5C, 1'b1, 25'h1FFFFFF, 8'hE7, 1, {1'b1, 23'h77FFFF, 2'b11, 16'hE75C}, '0, 0, 1};
    vecs[8] = '{25'h0FFFFE, 8'h01, 1'b1, 25'h0FFFFF, 8'h80, 1, {1'b0, 23'h07FFFF, 2'b11, 16'h8001}, '0, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check1("rst_req1", 64'(port1_req), 64'd0);
    check1("rst_req2", 64'(port2_req), 64'd0);
    check1("rst_state", 64'(dut.state), 64'(ST_IDLE));
    check1("rst_wait", 64'(ioctl_wait), 64'd0);
    check1("rst_done", 64'(done), 64'd0);
    check1("rst_port1", 64'({port1_we, port1_a, port1_ds, port1_d}), 64'd0);
    check1("rst_port2", 64'({port2_we, port2_a, port2_ds, port2_d}), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset lands while a port1 write sits in WAIT; controller completes it during reset
    ack_delay = 1000;
    exp_q.push_back({1'b0, 23'h0, 2'b11, 16'h1234});
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'h0, 8'h34);
    send_byte(25'h1, 8'h12);
    n = 0;
    while (!p1_active && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check1("fsm_in_wait", 64'(dut.state), 64'(ST_WAIT));
    complete_now = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk);
    check1("rwait_req1", 64'(port1_req), 64'd1);
    check1("rwait_state", 64'(dut.state), 64'(ST_IDLE));
    check1("rwait_wait", 64'(ioctl_wait), 64'd0);
    check1("rwait_port1", 64'({port1_we, port1_a, port1_ds, port1_d}), 64'd0);
    check1("rwait_done", 64'(done), 64'd0);
    reset = 1'b0;
    complete_now = 1'b0;
    ack_delay = 3;
    repeat (20) @(negedge clk);
    check1("rwait_no_toggle", 64'(p1_toggles), 64'd1);
    check1("rwait_no_toggle2", 64'(p2_toggles), 64'd0);

    // Table-driven downloads
    for (int i = 0; i < NV; i++) begin
      ack_delay = $urandom_range(1, 7);
      t1 = p1_toggles;
      t2 = p2_toggles;
      exp_q.push_back(vecs[i].e0);
      if (vecs[i].n_exp == 2) exp_q.push_back(vecs[i].e1);
      ioctl_download = 1'b1;
      repeat (2) @(negedge clk);
      check1($sformatf("vec%0d_done_low", i), 64'(done), 64'd0);
      send_byte(vecs[i].a0, vecs[i].b0);
      if (vecs[i].has1) send_byte(vecs[i].a1, vecs[i].b1);
      ioctl_download = 1'b0;
      wait_done($sformatf("vec%0d_done", i));
      check1($sformatf("vec%0d_p1_toggles", i), 64'(p1_toggles - t1), 64'(vecs[i].t1));
      check1($sformatf("vec%0d_p2_toggles", i), 64'(p2_toggles - t2), 64'(vecs[i].t2));
    end

    // Back-pressure: slow acks, 16-byte burst, HPS honours ioctl_wait
    ack_delay = 40;
    t1 = p1_toggles;
    for (int k = 0; k < 8; k++)
      exp_q.push_back({1'b0, 23'(k), 2'b11, burst_byte(2 * k + 1), burst_byte(2 * k)});
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
    saw_wait = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(25'(i), burst_byte(i));
    check1("bp_wait_seen", 64'(saw_wait), 64'd1);
    ioctl_download = 1'b0;
    wait_done("bp_done");
    check1("bp_write_count", 64'(p1_toggles - t1), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

endmodule
